// File: rtl/pfr_mem_pkg.sv
// Shared definitions for the data-memory bridge: FSM states, access sizes and
// the default bus timeout.
package pfr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int DEF_TIMEOUT = 255;

    // Number of bytes touched by an access of the given size.
    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/dmem_strb_gen.sv
// Byte-strobe and alignment decode for one access: size + low address bits in,
// write strobe and misaligned flag out.
module dmem_strb_gen
    import pfr_mem_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [1:0]     size,
    input  logic [2:0]     offset,
    output logic [N/8-1:0] strb,
    output logic           misaligned
);

    always_comb begin
        strb = '0;
        // Lanes above N/8 simply do not exist, which drops the upper strobe bits.
        for (int i = 0; i < N/8; i++) begin
            strb[i] = (i >= int'(offset)) && ((i - int'(offset)) < size_bytes(size));
        end

        misaligned = 1'b0;
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = offset[0];
            SZ_W:    misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle data-memory port onto a valid/ready request
// and response bus, stalling the core until the access completes or aborts.
module dmem_bridge
    import pfr_mem_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   DM_addr,
    input  logic [N-1:0]   DM_writeData,
    input  logic           DM_writeEnable,
    input  logic           DM_readEnable,
    input  logic [2:0]     memMask,
    output logic [N-1:0]   DM_readData,
    output logic           stall,
    output logic           busErr,
    output logic           bus_req_valid,
    input  logic           bus_req_ready,
    output logic           bus_req_we,
    output logic [N-1:0]   bus_req_addr,
    output logic [N-1:0]   bus_req_wdata,
    output logic [N/8-1:0] bus_req_strb,
    input  logic           bus_rsp_valid,
    input  logic [N-1:0]   bus_rsp_data,
    input  logic           bus_rsp_err,
    output logic           bus_rsp_ready,
    output state_t         dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [N-1:0]     addr_q, wdata_q, rdata_q;
    logic [N/8-1:0]   strb_q, strb_d;
    logic             we_q, err_q, misaligned;
    logic [CW-1:0]    tmo_cnt;
    logic             start, tmo_hit;

    // Sign-extension bit of memMask belongs to the downstream load formatter.
    logic unused_mask_sign;
    assign unused_mask_sign = memMask[2];

    dmem_strb_gen #(.N(N)) u_strb_gen (
        .size       (memMask[1:0]),
        .offset     (DM_addr[2:0]),
        .strb       (strb_d),
        .misaligned (misaligned)
    );

    assign start   = DM_readEnable | DM_writeEnable;
    assign tmo_hit = (tmo_cnt >= TMO_LAST);

    // Handshakes: a beat transfers on the rising edge where valid and ready are
    // both high; request fields are held constant from valid rising until then.
    always_comb begin
        state_n       = state;
        stall         = 1'b0;
        busErr        = 1'b0;
        bus_req_valid = 1'b0;
        bus_rsp_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall   = 1'b1;
                    state_n = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                stall         = 1'b1;
                bus_req_valid = 1'b1;
                if (bus_req_ready)  state_n = RESP;
                else if (tmo_hit)   state_n = DONE;
            end
            RESP: begin
                stall         = 1'b1;
                bus_rsp_ready = 1'b1;
                if (bus_rsp_valid)  state_n = DONE;
                else if (tmo_hit)   state_n = DONE;
            end
            default: begin
                busErr  = err_q;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= DM_addr;
                        wdata_q <= DM_writeData;
                        strb_q  <= strb_d;
                        we_q    <= DM_writeEnable;
                        err_q   <= misaligned;
                        tmo_cnt <= '0;
                        if (misaligned) rdata_q <= '0;
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (!bus_req_ready && tmo_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                RESP: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus_rsp_valid) begin
                        err_q <= bus_rsp_err;
                        if (!we_q) rdata_q <= bus_rsp_data;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DM_readData   = rdata_q;
    assign bus_req_we    = we_q;
    assign bus_req_addr  = addr_q;
    assign bus_req_wdata = wdata_q;
    assign bus_req_strb  = strb_q;
    assign dbg_state     = state;

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter N, default 64, meaning data and address width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent waiting in REQ+RESP before abort.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports DM_addr (N), DM_writeData (N), DM_writeEnable (1), DM_readEnable (1) and memMask (3), all inputs from the datapath; memMask[1:0] is the access size: 0 byte, 1 half, 2 word, 3 double.
REQ-006 SHALL have ports DM_readData (output, N), stall (output, 1; holds the core) and busErr (output, 1; a one-cycle error pulse).
REQ-007 SHALL have bus request ports: bus_req_valid (out, 1), bus_req_ready (in, 1), bus_req_we (out, 1), bus_req_addr (out, N), bus_req_wdata (out, N) and bus_req_strb (out, N/8).
REQ-008 SHALL have bus response ports: bus_rsp_valid (in, 1), bus_rsp_data (in, N), bus_rsp_err (in, 1) and bus_rsp_ready (out, 1).

Function
REQ-009 SHALL implement the FSM states IDLE, REQ, RESP and DONE.
REQ-010 IDLE, with DM_readEnable or DM_writeEnable high: SHALL drive stall=1 combinationally in the same cycle, latch addr, wdata, we and strb, and go to REQ.
REQ-011 Both enables high: SHALL treat the access as a write; the read is ignored.
REQ-012 Strobe: SHALL compute strb = ((1<<(1<<size))-1) << addr[2:0], with bits above N/8 discarded.
REQ-013 Misaligned access (addr not a multiple of 2^size): SHALL skip the bus, go IDLE->DONE, pulse busErr in DONE, and return DM_readData=0.
REQ-014 REQ: SHALL hold bus_req_valid=1 and all request fields stable until bus_req_ready=1, then go to RESP; the same-cycle valid&ready edge counts as the handshake.
REQ-015 RESP: SHALL drive bus_rsp_ready=1; on bus_rsp_valid it SHALL capture bus_rsp_data (reads only) and bus_rsp_err, then go to DONE.
REQ-016 Response data for writes: SHALL be discarded, and DM_readData SHALL keep its previous value.
REQ-017 DONE: SHALL drive stall=0 and DM_readData=the captured word, pulse busErr if an error was captured, and go unconditionally to IDLE (the core commits at this edge).
REQ-018 stall SHALL be 1 in REQ and RESP and 0 in DONE; in IDLE it SHALL follow REQ-010.
REQ-019 Timeout counter: SHALL clear on IDLE->REQ and increment every REQ/RESP cycle; on reaching TIMEOUT it SHALL go to DONE with busErr and DM_readData=0, dropping valid and ready.
REQ-020 A bus_rsp_valid arriving outside RESP SHALL be ignored, with bus_rsp_ready=0.
REQ-021 Latency with ready and rsp_valid both immediate SHALL be 3 cycles: IDLE->REQ->RESP->DONE, giving stall high for 3 cycles.
REQ-022 DM_readData SHALL be the raw aligned bus word; byte shifting and sign extension are done downstream.

Reset
REQ-023 Asserting reset, even mid-transaction, SHALL immediately force state IDLE, bus_req_valid=0, bus_rsp_ready=0, busErr=0, DM_readData=0, the timeout counter to 0 and all latched request fields to 0.
REQ-024 After reset deasserts, stall SHALL be 0 until a new enable is seen; aborted transactions are not replayed.

Structure
REQ-025 A shared package pfr_mem_pkg SHALL hold the FSM state enum, the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the default TIMEOUT constant.
REQ-026 The block SHALL have one sub-module, dmem_strb_gen (combinational size+offset -> strb and misaligned flag); everything else stays in dmem_bridge.

Verification
REQ-027 Read: DM_readEnable=1, addr=0x1000, size=3, ready and rsp_valid immediate with data 0xDEADBEEF_CAFEF00D -> strb=0xFF, stall high 3 cycles, DM_readData=0xDEADBEEF_CAFEF00D in DONE, busErr=0.
REQ-028 Byte write: addr=0x2005, size=0, wdata=0xAB -> strb=0x20, we=1, and request fields stay stable while ready is held low for 4 cycles.
REQ-029 Misaligned: addr=0x3002, size=2 -> no bus_req_valid, busErr pulse in DONE, and stall high for exactly 1 cycle.
REQ-030 Timeout: TIMEOUT=8 and bus_req_ready stuck 0 -> DONE after 8 REQ cycles, busErr=1, DM_readData=0, valid dropped.
REQ-031 Error response: a read with bus_rsp_err=1 -> busErr pulse in DONE; a concurrent read+write enable issues a write (we=1).
REQ-032 Reset in RESP: reset asserted mid-transaction -> valid and ready drop asynchronously, state IDLE, a late rsp_valid is ignored, and the next request proceeds normally.
